// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: result widths, the reserved "no dependency"
// tag, functional-unit indices and the CDB broadcast record.
package tomasulo_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int N_FU   = 3;

    // Tag 0 marks an operand with no outstanding producer, so it never names a result.
    localparam logic [TAG_W-1:0] NULL_TAG = '0;

    // Result producers, in CDB source-index order.
    localparam int FU_ADD = 0;
    localparam int FU_MUL = 1;
    localparam int FU_LD  = 2;

    // One CDB broadcast as snooped by the RS lines and the register-status table.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    // Event counter step that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches req starting at ptr, wrapping
// modulo N, and returns the first requester as a one-hot grant plus its index.
// The pointer register lives in the parent so the grant stays purely combinational.
module rr_arbiter #(
    parameter int  N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // Walk the requesters from ptr upward with wrap; the first one found wins.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        // NOTE: every output gets a default before the search, so a cycle with no
        // requester still assigns all of them and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr is below 2*N and k below N, so two conditional wraps suffice.
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (pos >= N) pos = pos - N;
            pos_idx = IDX_W'(pos);
            if (!grant_any && req[pos_idx]) begin
                grant[pos_idx] = 1'b1;
                grant_idx      = pos_idx;
                grant_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus scheduler. Each functional unit parks one finished result in
// a private holding buffer; one buffered result per cycle is broadcast on the
// registered CDB, chosen round-robin. Tag 0 is never broadcast: such offers are
// dropped and flagged on the sticky tag_err.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int  N_REQ  = N_FU,
    parameter int  TAG_W  = tomasulo_pkg::TAG_W,
    parameter int  DATA_W = tomasulo_pkg::DATA_W,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [SRC_W-1:0]        cdb_src,
    output logic [15:0]             conflict_cnt,
    output logic                    tag_err
);

    // Holding buffers, one entry per producer.
    logic [N_REQ-1:0]  buf_valid;
    logic [TAG_W-1:0]  buf_tag  [N_REQ];
    logic [DATA_W-1:0] buf_data [N_REQ];

    // Round-robin state and the current cycle's arbitration result.
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  next_ptr;
    logic [N_REQ-1:0]  grant;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_any;

    // Per-unit request qualification.
    logic [N_REQ-1:0]  accept;
    logic              null_offered;
    logic              multi_pending;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req       (buf_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A unit may hand over a result when its buffer is empty or is being drained
    // this cycle; this depends only on state, never on req_*.
    assign req_ready = ~buf_valid | grant;

    // Split offers into loadable results and tag-0 offers that must be dropped.
    always_comb begin
        accept       = '0;
        null_offered = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                if (req_tag[i*TAG_W +: TAG_W] == TAG_W'(NULL_TAG)) begin
                    null_offered = 1'b1;
                end else begin
                    accept[i] = req_ready[i];
                end
            end
        end
    end

    // Pointer moves to the unit after the winner so it has lowest priority next cycle.
    always_comb begin
        if (grant_idx == SRC_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + SRC_W'(1);
        end
    end

    assign multi_pending = ($countones(buf_valid) >= 2);

    // Buffer occupancy: a same-edge refill wins over the drain, keeping the entry live.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i]) begin
                    // NOTE: non-blocking assignment, so every flop here samples the
                    // pre-edge values of grant/accept regardless of statement order.
                    buf_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Buffer payload loads on accept only.
    // NOTE: payload has no reset; buf_valid is cleared on reset and gates every use.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                buf_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                buf_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered CDB broadcast of the granted buffer; idle cycles drive zeros.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (grant_any) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= buf_tag[grant_idx];
            cdb_data  <= buf_data[grant_idx];
            cdb_src   <= grant_idx;
            rr_ptr    <= next_ptr;
        end else begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end
    end

    // Contention counter (occupancy sampled before update) and sticky tag-0 flag.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            conflict_cnt <= '0;
            tag_err      <= 1'b0;
        end else begin
            if (multi_pending) begin
                conflict_cnt <= sat_inc16(conflict_cnt);
            end
            if (null_offered) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with hand-computed expectations plus
// a long randomized run, all compared every cycle against a behavioural model
// that keeps one pending result per unit and picks the winner by a modular scan.
module tb_cdb_arbiter;
    import tomasulo_pkg::*;

    localparam int N  = 3;
    localparam int TW = 3;
    localparam int DW = 16;
    localparam int SW = 2;

    logic              Clock = 1'b0;
    logic              Resetn;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [SW-1:0]     cdb_src;
    logic [15:0]       conflict_cnt;
    logic              tag_err;

    cdb_arbiter dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .req_valid    (req_valid),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src),
        .conflict_cnt (conflict_cnt),
        .tag_err      (tag_err)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit   m_pend [N];
    cdb_t m_ent  [N];
    int   m_ptr;
    cdb_t m_cdb;
    int   m_src;
    int   m_conf;
    bit   m_err;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_ent[i]  = '0;
        end
        m_ptr  = 0;
        m_cdb  = '0;
        m_src  = 0;
        m_conf = 0;
        m_err  = 1'b0;
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit model_ready(input int i);
        return !m_pend[i] || (model_winner() == i);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        int w;
        int cnt;
        bit was_pend [N];
        logic [TW-1:0] t;
        w   = model_winner();
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            was_pend[i] = m_pend[i];
            if (m_pend[i]) cnt++;
        end
        if (cnt >= 2 && m_conf < 65535) m_conf++;
        if (w >= 0) begin
            m_cdb       = m_ent[w];
            m_cdb.valid = 1'b1;
            m_src       = w;
            m_ptr       = (w + 1) % N;
            m_pend[w]   = 1'b0;
        end else begin
            m_cdb = '0;
        end
        for (int i = 0; i < N; i++) begin
            t = req_tag[i*TW +: TW];
            if (req_valid[i]) begin
                if (t == 0) begin
                    m_err = 1'b1;
                end else if (!was_pend[i] || i == w) begin
                    m_pend[i]     = 1'b1;
                    m_ent[i].tag  = t;
                    m_ent[i].data = req_data[i*DW +: DW];
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_valid[i]       = v;
        req_tag[i*TW +: TW] = t;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
    endtask

    // One cycle: check ready before the edge, then all CDB outputs just after it.
    task automatic step();
        for (int i = 0; i < N; i++) begin
            check($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(model_ready(i)));
        end
        model_edge();
        @(posedge Clock);
        #1;
        check("cdb_valid", 32'(cdb_valid), 32'(m_cdb.valid));
        check("cdb_tag", 32'(cdb_tag), 32'(m_cdb.tag));
        check("cdb_data", 32'(cdb_data), 32'(m_cdb.data));
        if (m_cdb.valid) check("cdb_src", 32'(cdb_src), 32'(m_src));
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        check("tag_err", 32'(tag_err), 32'(m_err));
    endtask

    // Asynchronous assert away from the edge, literal reset checks, release mid-cycle.
    task automatic do_reset();
        clear_req();
        Resetn = 1'b0;
        #1;
        check("rst cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'b111);
        check("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
        check("rst tag_err", 32'(tag_err), 32'd0);
        model_reset();
        @(posedge Clock);
        #2;
        Resetn = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    bit            hold  [N];
    logic [TW-1:0] htag  [N];
    logic [DW-1:0] hdata [N];

    initial begin
        int a_cyc;
        int b_cyc;
        int u0_bc;
        int u0_tag;
        bit u2_on;
        bit rdy0;
        bit rdy2;
        bit rdy [N];
        int prob;

        Resetn = 1'b0;
        clear_req();
        #3;
        do_reset();

        // Single result from unit 0: one-cycle broadcast after the following edge.
        set_req(0, 1'b1, 3'd1, 16'h0005);
        step();
        clear_req();
        check("s2 not yet", 32'(cdb_valid), 32'd0);
        step();
        check("s2 valid", 32'(cdb_valid), 32'd1);
        check("s2 tag", 32'(cdb_tag), 32'd1);
        check("s2 data", 32'(cdb_data), 32'h5);
        check("s2 src", 32'(cdb_src), 32'd0);
        step();
        check("s2 one cycle", 32'(cdb_valid), 32'd0);

        // Three simultaneous results: broadcast in source order, two contended edges.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i + 1), 16'(16'h100 * (i + 1)));
        step();
        clear_req();
        for (int i = 0; i < N; i++) begin
            step();
            check("s3 src order", 32'(cdb_src), 32'(i));
            check("s3 tag order", 32'(cdb_tag), 32'(i + 1));
        end
        check("s3 conflict", 32'(conflict_cnt), 32'd2);
        step();
        check("s3 drained", 32'(cdb_valid), 32'd0);

        // Reset while results are buffered discards them.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i + 4), 16'hA0A0);
        step();
        clear_req();
        step();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            check("s1 nothing after reset", 32'(cdb_valid), 32'd0);
        end

        // Unit 0 streams while unit 2 holds one result.
        do_reset();
        u0_tag = 1;
        u2_on  = 1'b1;
        a_cyc  = -1;
        b_cyc  = -1;
        u0_bc  = 0;
        for (int c = 0; c < 10; c++) begin
            set_req(0, 1'b1, 3'(u0_tag), 16'($urandom));
            set_req(2, u2_on, 3'd5, 16'h2222);
            rdy0 = model_ready(0);
            rdy2 = model_ready(2);
            step();
            if (rdy0) u0_tag = (u0_tag % 7) + 1;
            if (u2_on && rdy2) begin
                u2_on = 1'b0;
                a_cyc = c;
            end
            if (cdb_valid && cdb_src == 2'd2 && b_cyc < 0) b_cyc = c;
            if (cdb_valid && cdb_src == 2'd0) u0_bc++;
        end
        clear_req();
        check("s4 u2 accepted", 32'(a_cyc), 32'd0);
        check("s4 u2 latency", 32'(b_cyc - a_cyc), 32'd2);
        check("s4 u0 throughput", 32'(u0_bc), 32'd8);

        // Tag 0 is dropped and sets the sticky error.
        do_reset();
        set_req(1, 1'b1, 3'd0, 16'hBEEF);
        step();
        clear_req();
        check("s5 no bcast", 32'(cdb_valid), 32'd0);
        check("s5 tag_err", 32'(tag_err), 32'd1);
        for (int k = 0; k < 3; k++) step();
        check("s5 tag_err sticky", 32'(tag_err), 32'd1);
        check("s5 still no bcast", 32'(cdb_valid), 32'd0);

        // Back-to-back refill on unit 0: tags 1..4 on consecutive cycles.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) set_req(0, 1'b1, 3'(k), 16'(k * 16'h11));
            else clear_req();
            if (k <= 4) check("s6 ready", 32'(req_ready[0]), 32'd1);
            step();
            if (k >= 2) begin
                check("s6 valid", 32'(cdb_valid), 32'd1);
                check("s6 tag", 32'(cdb_tag), 32'(k - 1));
            end
        end

        // Randomized traffic with varying load and occasional reset.
        do_reset();
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            case ((c / 400) % 3)
                0:       prob = 20;
                1:       prob = 60;
                default: prob = 95;
            endcase
            if (c % 997 == 500) begin
                do_reset();
                for (int i = 0; i < N; i++) hold[i] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!hold[i] && $urandom_range(0, 99) < prob) begin
                    hold[i]  = 1'b1;
                    htag[i]  = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
                    hdata[i] = 16'($urandom);
                end
                set_req(i, hold[i], htag[i], hdata[i]);
                rdy[i] = model_ready(i);
            end
            step();
            for (int i = 0; i < N; i++) begin
                if (hold[i] && (rdy[i] || htag[i] == 3'd0)) hold[i] = 1'b0;
            end
        end
        clear_req();
        for (int k = 0; k < 4; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
